// File: rtl/l1_trigger_holdoff_scaler.sv
// Per-beam trigger edge detect with mask and holdoff, single-cycle accept pulses,
// and saturating per-beam rate counts published once per programmable gate period.
module l1_trigger_holdoff_scaler #(
  parameter int unsigned NBEAMS       = 2,
  parameter int unsigned HOLDOFF_BITS = 8,
  parameter int unsigned COUNT_BITS   = 24,
  parameter int unsigned PERIOD_BITS  = 27
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NBEAMS-1:0]              trig_i,
  input  logic [NBEAMS-1:0]              beam_mask_i,
  input  logic [HOLDOFF_BITS-1:0]        holdoff_i,
  input  logic [PERIOD_BITS-1:0]         period_i,
  output logic [NBEAMS-1:0]              trig_o,
  output logic                           any_trig_o,
  output logic [NBEAMS*COUNT_BITS-1:0]   count_o,
  output logic                           count_valid_o
);

  localparam int unsigned COUNT_W = NBEAMS * COUNT_BITS;

  typedef enum logic {READY, HOLD} beam_state_e;
  typedef enum logic {LOAD, RUN} per_state_e;

  beam_state_e                          beam_st_q [NBEAMS];
  beam_state_e                          beam_st_d [NBEAMS];
  logic [NBEAMS-1:0][HOLDOFF_BITS-1:0]  hcnt_q, hcnt_d;
  logic [NBEAMS-1:0][COUNT_BITS-1:0]    run_q, run_d, inc;
  logic [NBEAMS-1:0]                    trig_prev, rise, accept;
  per_state_e                           per_state_q, per_state_d;
  logic [PERIOD_BITS-1:0]               per_cnt_q, per_cnt_d;
  logic                                 terminal;

  // Next-state logic for the gate-period FSM and every beam FSM
  always_comb begin
    per_state_d = per_state_q;
    per_cnt_d   = per_cnt_q;
    terminal    = 1'b0;
    case (per_state_q)
      LOAD: begin
        per_cnt_d   = period_i;
        per_state_d = RUN;
      end
      RUN: begin
        if (per_cnt_q == '0) begin
          terminal  = 1'b1;
          per_cnt_d = period_i;
        end else begin
          per_cnt_d = per_cnt_q - PERIOD_BITS'(1);
        end
      end
      default: per_state_d = LOAD;
    endcase

    for (int b = 0; b < int'(NBEAMS); b++) begin
      beam_st_d[b] = beam_st_q[b];
      hcnt_d[b]    = hcnt_q[b];
      accept[b]    = 1'b0;
      rise[b]      = trig_i[b] & ~trig_prev[b] & ~beam_mask_i[b];
      case (beam_st_q[b])
        READY: begin
          if (rise[b]) begin
            accept[b] = 1'b1;
            hcnt_d[b] = holdoff_i;
            if (holdoff_i != '0) beam_st_d[b] = HOLD;
          end
        end
        HOLD: begin
          // Mask changes do not cut the dead time short
          hcnt_d[b] = hcnt_q[b] - HOLDOFF_BITS'(1);
          if (hcnt_q[b] == HOLDOFF_BITS'(1)) beam_st_d[b] = READY;
        end
        default: beam_st_d[b] = READY;
      endcase
      inc[b]   = (accept[b] && (run_q[b] != '1)) ? run_q[b] + COUNT_BITS'(1) : run_q[b];
      run_d[b] = terminal ? '0 : inc[b];
    end
  end

  // State and registered outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      trig_prev     <= '1;
      trig_o        <= '0;
      any_trig_o    <= 1'b0;
      count_o       <= COUNT_W'(0);
      count_valid_o <= 1'b0;
      per_state_q   <= LOAD;
      per_cnt_q     <= '0;
      hcnt_q        <= '0;
      run_q         <= '0;
      for (int b = 0; b < int'(NBEAMS); b++) beam_st_q[b] <= READY;
    end else begin
      trig_prev     <= trig_i;
      trig_o        <= accept;
      any_trig_o    <= |accept;
      count_valid_o <= terminal;
      per_state_q   <= per_state_d;
      per_cnt_q     <= per_cnt_d;
      hcnt_q        <= hcnt_d;
      run_q         <= run_d;
      for (int b = 0; b < int'(NBEAMS); b++) begin
        beam_st_q[b] <= beam_st_d[b];
        // Terminal-cycle accepts belong to the closing gate
        if (terminal) count_o[b*COUNT_BITS +: COUNT_BITS] <= inc[b];
      end
    end
  end

endmodule
